// File: rtl/rgmii_rx_pkg.sv
// Shared types and constants for the RGMII receive path.
// Contents: FSM state enum, preamble/SFD byte values, CRC32 seed, residue
// and polynomial, delay-line depth, and a byte-wise reflected CRC32 update.
package rgmii_rx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      DATA = 2'd2,
      DROP = 2'd3
   } rx_state_t;

   localparam logic [7:0]  preamble_c    = 8'h55;
   localparam logic [7:0]  sfd_c         = 8'hD5;
   localparam logic [31:0] crc_init_c    = 32'hFFFFFFFF;
   localparam logic [31:0] crc_residue_c = 32'hDEBB20E3;
   localparam logic [31:0] crc_poly_c    = 32'hEDB88320;

   // The FCS is 4 bytes, so holding 5 lets the frame end emit the last data
   // byte while the 4 FCS bytes are discarded.
   localparam int          line_depth_c  = 5;

   // Reflected CRC32, byte consumed LSB first, no final inversion.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                              input logic [7:0]  data);
      logic [31:0] c;
      c = crc ^ {24'h000000, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ crc_poly_c) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/rgmii_rx_ddr_capture.sv
// RGMII receive pin capture and byte assembly.
// Ports:
//   rgmii_txd_reference_clk  in   RX reference clock
//   reset_clk125_i           in   asynchronous active-low reset
//   ddr_mode                 in   1: 1000 DDR byte per cycle, 0: nibble per cycle
//   rgmii_rxd_i[3:0]         in   RX data pins
//   rgmii_rx_ctl_i           in   RX_CTL pin
//   byte_v                   out  rx_byte holds a complete byte this cycle
//   rx_byte[7:0]             out  assembled byte
//   dv                       out  RX_DV
//   er                       out  RX_ER (DDR only, 0 in nibble mode)
// All outputs are registered on the rising edge.
module rgmii_rx_ddr_capture (
   input  logic       rgmii_txd_reference_clk,
   input  logic       reset_clk125_i,
   input  logic       ddr_mode,
   input  logic [3:0] rgmii_rxd_i,
   input  logic       rgmii_rx_ctl_i,
   output logic       byte_v,
   output logic [7:0] rx_byte,
   output logic       dv,
   output logic       er
);

   logic [3:0] lo_p;
   logic [3:0] hi_n;
   logic [3:0] lo_nib;
   logic       dv_p;
   logic       ctl_n;
   logic       phase;

   always_ff @(negedge rgmii_txd_reference_clk or negedge reset_clk125_i) begin
      if (!reset_clk125_i) begin
         hi_n  <= 4'h0;
         ctl_n <= 1'b0;
      end else begin
         hi_n  <= rgmii_rxd_i;
         ctl_n <= rgmii_rx_ctl_i;
      end
   end

   // DDR: the rising-edge half (lo_p, dv_p) and the falling-edge half
   // (hi_n, ctl_n) of one byte are joined on the next rising edge.
   always_ff @(posedge rgmii_txd_reference_clk or negedge reset_clk125_i) begin
      if (!reset_clk125_i) begin
         lo_p    <= 4'h0;
         dv_p    <= 1'b0;
         lo_nib  <= 4'h0;
         phase   <= 1'b0;
         byte_v  <= 1'b0;
         rx_byte <= 8'h00;
         dv      <= 1'b0;
         er      <= 1'b0;
      end else begin
         lo_p <= rgmii_rxd_i;
         dv_p <= rgmii_rx_ctl_i;
         if (ddr_mode) begin
            rx_byte <= {hi_n, lo_p};
            dv      <= dv_p;
            er      <= dv_p ^ ctl_n;
            byte_v  <= dv_p;
            phase   <= 1'b0;
         end else begin
            dv <= rgmii_rx_ctl_i;
            er <= 1'b0;
            if (!rgmii_rx_ctl_i) begin
               phase  <= 1'b0;
               byte_v <= 1'b0;
            end else if (!phase) begin
               lo_nib <= rgmii_rxd_i;
               phase  <= 1'b1;
               byte_v <= 1'b0;
            end else begin
               rx_byte <= {rgmii_rxd_i, lo_nib};
               phase   <= 1'b0;
               byte_v  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rgmii_rx_frame_decoder.sv
// MAC-side RGMII frame receiver: strips preamble/SFD, checks FCS and length,
// and streams frame bytes (FCS removed) with valid/last/err framing.
// Ports:
//   rgmii_txd_reference_clk  in   RX reference clock
//   reset_clk125_i           in   asynchronous active-low reset
//   speed_i[1:0]             in   2'b10 = 1000 DDR, 2'b01/2'b00 = 100/10 nibble
//   rgmii_rxd_i[3:0]         in   RX data pins
//   rgmii_rx_ctl_i           in   RX_CTL pin
//   data_o[7:0]              out  frame byte, destination address first
//   v_o                      out  data_o valid for one cycle
//   last_o                   out  final emitted byte of the frame
//   err_o                    out  with last_o: frame is bad
//   good_frames_o            out  frames ended with err_o = 0 (wraps)
//   bad_frames_o             out  frames ended with err_o = 1 or dropped (wraps)
//
// state | meaning
// IDLE  | waiting for the first preamble byte
// PRE   | inside preamble, waiting for SFD
// DATA  | frame bytes flowing through the 5-byte delay line
// DROP  | discarding bytes until RX_DV falls
module rgmii_rx_frame_decoder
   import rgmii_rx_pkg::*;
#(
   parameter int min_frame_p = 64,
   parameter int max_frame_p = 1518,
   parameter int cnt_width_p = 16
) (
   input  logic                   rgmii_txd_reference_clk,
   input  logic                   reset_clk125_i,
   input  logic [1:0]             speed_i,
   input  logic [3:0]             rgmii_rxd_i,
   input  logic                   rgmii_rx_ctl_i,
   output logic [7:0]             data_o,
   output logic                   v_o,
   output logic                   last_o,
   output logic                   err_o,
   output logic [cnt_width_p-1:0] good_frames_o,
   output logic [cnt_width_p-1:0] bad_frames_o
);

   localparam logic [15:0] min_len_c = 16'(min_frame_p);
   localparam logic [15:0] max_len_c = 16'(max_frame_p);
   localparam logic [2:0]  full_c    = 3'(line_depth_c);

   rx_state_t   state_q, state_n;
   logic        byte_v, dv, er;
   logic [7:0]  rx_byte;
   logic [1:0]  speed_q;
   logic [31:0] crc_q, crc_n;
   logic [15:0] len_q, len_n;
   logic [2:0]  cnt_q, cnt_n;
   logic [7:0]  line_q [line_depth_c];
   logic        push;
   logic        v_n, last_n, err_n;
   logic [7:0]  data_n;
   logic        good_inc, bad_inc;
   logic        line_full, abort, frame_bad;

   rgmii_rx_ddr_capture u_capture (
      .rgmii_txd_reference_clk (rgmii_txd_reference_clk),
      .reset_clk125_i          (reset_clk125_i),
      .ddr_mode                (speed_i[1]),
      .rgmii_rxd_i             (rgmii_rxd_i),
      .rgmii_rx_ctl_i          (rgmii_rx_ctl_i),
      .byte_v                  (byte_v),
      .rx_byte                 (rx_byte),
      .dv                      (dv),
      .er                      (er)
   );

   assign line_full = (cnt_q == full_c);
   // A byte arriving when max_frame_p bytes are already counted would make
   // the frame one byte too long.
   assign abort     = er || (speed_i != speed_q) || (byte_v && (len_q == max_len_c));
   assign frame_bad = (crc_q != crc_residue_c) || (len_q < min_len_c);

   always_ff @(posedge rgmii_txd_reference_clk or negedge reset_clk125_i) begin
      if (!reset_clk125_i) begin
         state_q       <= IDLE;
         speed_q       <= 2'b00;
         crc_q         <= crc_init_c;
         len_q         <= 16'h0000;
         cnt_q         <= 3'd0;
         for (int i = 0; i < line_depth_c; i++) line_q[i] <= 8'h00;
         data_o        <= 8'h00;
         v_o           <= 1'b0;
         last_o        <= 1'b0;
         err_o         <= 1'b0;
         good_frames_o <= '0;
         bad_frames_o  <= '0;
      end else begin
         state_q <= state_n;
         speed_q <= speed_i;
         crc_q   <= crc_n;
         len_q   <= len_n;
         cnt_q   <= cnt_n;
         if (push) begin
            for (int i = line_depth_c - 1; i > 0; i--) line_q[i] <= line_q[i-1];
            line_q[0] <= rx_byte;
         end
         data_o        <= data_n;
         v_o           <= v_n;
         last_o        <= last_n;
         err_o         <= err_n;
         good_frames_o <= good_frames_o + cnt_width_p'(good_inc);
         bad_frames_o  <= bad_frames_o + cnt_width_p'(bad_inc);
      end
   end

   always_comb begin
      state_n = state_q;
      unique case (state_q)
         IDLE: begin
            if (dv && byte_v) state_n = (rx_byte == preamble_c) ? PRE : DROP;
         end
         PRE: begin
            if (!dv) begin
               state_n = IDLE;
            end else if (byte_v) begin
               if (rx_byte == sfd_c)           state_n = DATA;
               else if (rx_byte != preamble_c) state_n = DROP;
            end
         end
         DATA: begin
            if (!dv)        state_n = IDLE;
            else if (abort) state_n = DROP;
         end
         DROP: begin
            if (!dv) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      v_n      = 1'b0;
      last_n   = 1'b0;
      err_n    = 1'b0;
      push     = 1'b0;
      crc_n    = crc_q;
      len_n    = len_q;
      cnt_n    = cnt_q;
      good_inc = 1'b0;
      bad_inc  = 1'b0;
      unique case (state_q)
         PRE: begin
            if (dv && byte_v && (rx_byte == sfd_c)) begin
               crc_n = crc_init_c;
               len_n = 16'h0000;
               cnt_n = 3'd0;
            end
         end
         DATA: begin
            if (!dv) begin
               // Fewer than 5 bytes means nothing was emitted yet: a runt
               // is counted but never appears on the stream.
               if (line_full) begin
                  v_n      = 1'b1;
                  last_n   = 1'b1;
                  err_n    = frame_bad;
                  good_inc = !frame_bad;
                  bad_inc  = frame_bad;
               end else begin
                  bad_inc = 1'b1;
               end
            end else if (abort) begin
               if (line_full) begin
                  v_n    = 1'b1;
                  last_n = 1'b1;
                  err_n  = 1'b1;
               end
            end else if (byte_v) begin
               crc_n = crc32_byte(crc_q, rx_byte);
               len_n = len_q + 16'h0001;
               push  = 1'b1;
               if (line_full) v_n = 1'b1;
               else           cnt_n = cnt_q + 3'd1;
            end
         end
         default: ;
      endcase
      if ((state_q != DROP) && (state_n == DROP)) bad_inc = 1'b1;
      data_n = v_n ? line_q[line_depth_c-1] : 8'h00;
   end

endmodule

// File: tb/tb_rgmii_rx_frame_decoder.sv
module tb_rgmii_rx_frame_decoder;

   localparam int MIN = 64;
   localparam int MAX = 100;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic [1:0]  speed = 2'b10;
   logic [3:0]  rxd = 4'h0;
   logic        ctl = 1'b0;
   logic [7:0]  data_o;
   logic        v_o, last_o, err_o;
   logic [15:0] good_o, bad_o;

   always #4 clk = ~clk;

   rgmii_rx_frame_decoder #(
      .min_frame_p (MIN),
      .max_frame_p (MAX),
      .cnt_width_p (16)
   ) dut (
      .rgmii_txd_reference_clk (clk),
      .reset_clk125_i          (rst_b),
      .speed_i                 (speed),
      .rgmii_rxd_i             (rxd),
      .rgmii_rx_ctl_i          (ctl),
      .data_o                  (data_o),
      .v_o                     (v_o),
      .last_o                  (last_o),
      .err_o                   (err_o),
      .good_frames_o           (good_o),
      .bad_frames_o            (bad_o)
   );

   typedef struct {
      logic [7:0] d;
      logic       l;
      logic       e;
   } beat_t;

   beat_t      exp_q[$];
   logic [7:0] body[$];
   int         checks = 0;
   int         failures = 0;
   int         mgood = 0;
   int         mbad = 0;
   int         beats_total = 0;
   int         b0 = 0;
   logic [7:0] last_data = 8'h00;
   bit         nib_mode = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Standard Ethernet FCS over body[0..n-1], computed one bit at a time.
   function automatic logic [31:0] ref_crc(input int n);
      logic [31:0] c;
      bit          fb;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ body[i][k];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
         end
      end
      return ~c;
   endfunction

   initial begin
      beat_t b;
      forever begin
         @(negedge clk);
         if (!rst_b) begin
            chk("rst_data", data_o, 0);
            chk("rst_v", v_o, 0);
            chk("rst_last", last_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_good", good_o, 0);
            chk("rst_bad", bad_o, 0);
         end else if (v_o) begin
            beats_total++;
            last_data = data_o;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat actual=%h required=no_beat", data_o);
            end else begin
               b = exp_q.pop_front();
               chk("beat_data", data_o, b.d);
               chk("beat_last", last_o, b.l);
               chk("beat_err", err_o, b.e);
            end
         end
      end
   end

   task automatic drive_byte(input logic [7:0] bv, input bit er);
      if (nib_mode) begin
         @(negedge clk); #1; rxd = bv[3:0]; ctl = 1'b1;
         @(negedge clk); #1; rxd = bv[7:4]; ctl = 1'b1;
      end else begin
         @(negedge clk); #1; rxd = bv[3:0]; ctl = 1'b1;
         @(posedge clk); #1; rxd = bv[7:4]; ctl = 1'b1 ^ er;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk); #1; rxd = 4'h0; ctl = 1'b0;
      end
   endtask

   task automatic build(input int npay, input bit flip);
      logic [31:0] f;
      body.delete();
      for (int i = 0; i < npay; i++) body.push_back(8'(i));
      f = ref_crc(npay);
      if (flip) f[0] = ~f[0];
      body.push_back(f[7:0]);
      body.push_back(f[15:8]);
      body.push_back(f[23:16]);
      body.push_back(f[31:24]);
   endtask

   // Frame-level expectation: a frame that stops after j counted bytes
   // (dv drop, rx_er, or overlength) streams bytes 0..j-5, last on j-5.
   task automatic model(input int er_at);
      int         n, j;
      bit         aborted, fcs_ok, err;
      logic [31:0] fr;
      beat_t      bt;
      n = body.size();
      j = n;
      aborted = 1'b0;
      if (er_at >= 0 && er_at < j) begin j = er_at; aborted = 1'b1; end
      if (j > MAX) begin j = MAX; aborted = 1'b1; end
      fcs_ok = 1'b0;
      if (n >= 4) begin
         fr = {body[n-1], body[n-2], body[n-3], body[n-4]};
         fcs_ok = (ref_crc(n - 4) == fr);
      end
      err = aborted || (j < MIN) || !fcs_ok;
      if (j >= 5) begin
         for (int k = 0; k <= j - 5; k++) begin
            bt.d = body[k];
            bt.l = (k == j - 5);
            bt.e = (k == j - 5) && err;
            exp_q.push_back(bt);
         end
      end
      if (j >= 5 && !err) mgood++;
      else                mbad++;
   endtask

   task automatic send(input int er_at, input int rst_at);
      repeat (7) drive_byte(8'h55, 1'b0);
      drive_byte(8'hD5, 1'b0);
      for (int i = 0; i < body.size(); i++) begin
         if (i == rst_at) begin
            rst_b = 1'b0;
            ctl   = 1'b0;
            rxd   = 4'h0;
            exp_q.delete();
            mgood = 0;
            mbad  = 0;
            repeat (3) @(negedge clk);
            #1 rst_b = 1'b1;
            break;
         end
         drive_byte(body[i], (i == er_at));
         if (er_at >= 0 && i == er_at + 3) chk("er_latency", exp_q.size(), 0);
      end
      idle(12);
      chk("drained", exp_q.size(), 0);
      chk("good_cnt", good_o, mgood);
      chk("bad_cnt", bad_o, mbad);
   endtask

   initial begin
      body = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      chk("crc_pin", ref_crc(9), 32'hCBF43926);

      idle(3);
      #1 rst_b = 1'b1;
      idle(4);

      // 1000, clean 64-byte payload
      build(64, 1'b0); b0 = beats_total; model(-1); send(-1, -1);
      chk("t1_beats", beats_total - b0, 64);
      chk("t1_last", last_data, 8'h3F);
      chk("t1_good", good_o, 1);
      chk("t1_bad", bad_o, 0);

      // FCS bit flipped
      build(64, 1'b1); b0 = beats_total; model(-1); send(-1, -1);
      chk("t2_beats", beats_total - b0, 64);
      chk("t2_bad", bad_o, 1);

      // 100 nibble mode
      nib_mode = 1'b1; speed = 2'b01; idle(4);
      build(64, 1'b0); b0 = beats_total; model(-1); send(-1, -1);
      chk("t3_beats", beats_total - b0, 64);
      chk("t3_last", last_data, 8'h3F);
      chk("t3_good", good_o, 2);

      // rx_er on the 30th byte
      nib_mode = 1'b0; speed = 2'b10; idle(4);
      build(64, 1'b0); b0 = beats_total; model(29); send(29, -1);
      chk("t4_beats", beats_total - b0, 25);
      chk("t4_last", last_data, 8'h18);
      chk("t4_bad", bad_o, 2);

      // runt with valid FCS
      build(20, 1'b0); b0 = beats_total; model(-1); send(-1, -1);
      chk("t5_beats", beats_total - b0, 20);
      chk("t5_last", last_data, 8'h13);

      // 3-byte frame
      body = '{8'hAA, 8'hBB, 8'hCC};
      b0 = beats_total; model(-1); send(-1, -1);
      chk("t6_beats", beats_total - b0, 0);
      chk("t6_bad", bad_o, 4);

      // exactly max length, then one beyond
      build(96, 1'b0); b0 = beats_total; model(-1); send(-1, -1);
      chk("t7_beats", beats_total - b0, 96);
      chk("t7_good", good_o, 3);
      build(106, 1'b0); b0 = beats_total; model(-1); send(-1, -1);
      chk("t8_beats", beats_total - b0, 96);
      chk("t8_last", last_data, 8'h5F);
      chk("t8_bad", bad_o, 5);

      // reset during byte 40, then a clean frame
      build(64, 1'b0);
      for (int k = 0; k <= 40; k++) begin
         beat_t bt;
         bt.d = body[k]; bt.l = 1'b0; bt.e = 1'b0;
         exp_q.push_back(bt);
      end
      send(-1, 40);
      chk("t9_good_after_rst", good_o, 0);
      chk("t9_bad_after_rst", bad_o, 0);
      build(64, 1'b0); b0 = beats_total; model(-1); send(-1, -1);
      chk("t9_beats", beats_total - b0, 64);
      chk("t9_good", good_o, 1);
      chk("t9_bad", bad_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
